// File: rtl/own_data_framer.sv
// own_data_framer: snapshots a multi-byte local player state and sends it to
// the UART TX FIFO as a framed packet: SYNC, PLAYER_ID, payload (LSB first)
// and, when OWN_DATA_CHKSUM_EN is defined, an XOR checksum of the ID and
// payload bytes. A frame goes out after reset, on any change of in_data and
// on a keep-alive timer (REFRESH clk cycles of idle, 0 disables it).
//
// FIFO handshake: tx_data is valid only while wr_uart=1, and wr_uart is a
// one-cycle pulse per byte. A byte is written only on an edge where tx_full=0.
// Every write is followed by one GAP cycle with wr_uart=0, so tx_full can
// reflect that write before the next byte is offered. While tx_full=1 the
// byte state is held and no write is made.
//
// The FSM state is held in 'state' (IDLE/SYNC/ID/PAY/CHK/GAP encodings below)
// so checkers can bind to it directly.
module own_data_framer #(
   parameter int         NBYTES    = 2,
   parameter logic [7:0] SYNC      = 8'hA5,
   parameter logic [7:0] PLAYER_ID = 8'h01,
   parameter int         REFRESH   = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_full,
   input  logic [8*NBYTES-1:0]   in_data,
   output logic [7:0]            tx_data,
   output logic                  wr_uart,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   localparam int             IW         = $clog2(NBYTES) + 1;
   localparam logic [IW-1:0]  LAST_IDX   = IW'(NBYTES - 1);
   localparam logic [31:0]    TIMER_LAST = (REFRESH == 0) ? 32'd0 : 32'(REFRESH - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYNC = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_PAY  = 3'd3;
`ifdef OWN_DATA_CHKSUM_EN
   localparam logic [2:0] S_CHK  = 3'd4;
`endif
   localparam logic [2:0] S_GAP  = 3'd5;

   logic [2:0]          state;
   logic [2:0]          ret_state;    // byte state to resume after GAP
   logic [8*NBYTES-1:0] snap;         // frozen copy sent in the current frame
   logic [8*NBYTES-1:0] last_sent;    // value of the last frame, for change detection
   logic [IW-1:0]       idx;          // payload byte index
   logic [31:0]         timer;        // idle cycles since the last frame
   logic                force_frame;  // send one frame after reset unconditionally
`ifdef OWN_DATA_CHKSUM_EN
   logic [7:0]          chk;          // running XOR of ID and payload bytes
`endif

   logic [7:0] pay_byte;
   logic       keepalive_hit;
   logic       trigger;

   assign keepalive_hit = (REFRESH != 0) && (timer == TIMER_LAST);
   assign trigger       = force_frame || (in_data != last_sent) || keepalive_hit;

   // Select the payload byte addressed by idx from the frozen snapshot.
   always_comb begin
      pay_byte = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == IW'(i)) pay_byte = snap[8*i +: 8];
      end
   end

   // Frame sequencer: trigger detection, byte emission with back-pressure, GAP pacing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ret_state   <= S_IDLE;
         snap        <= '0;
         last_sent   <= '0;
         idx         <= '0;
         timer       <= 32'd0;
         force_frame <= 1'b1;
         tx_data     <= 8'h00;
         wr_uart     <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= 16'h0000;
`ifdef OWN_DATA_CHKSUM_EN
         chk         <= 8'h00;
`endif
      end else begin
         wr_uart <= 1'b0;
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  snap        <= in_data;
                  last_sent   <= in_data;
                  force_frame <= 1'b0;
                  timer       <= 32'd0;
                  idx         <= '0;
                  busy        <= 1'b1;
                  state       <= S_SYNC;
               end else if ((REFRESH != 0) && (timer != TIMER_LAST)) begin
                  timer <= timer + 32'd1;
               end
            end
            S_SYNC: begin
               if (!tx_full) begin
                  tx_data   <= SYNC;
                  wr_uart   <= 1'b1;
                  ret_state <= S_ID;
                  state     <= S_GAP;
               end
            end
            S_ID: begin
               if (!tx_full) begin
                  tx_data   <= PLAYER_ID;
                  wr_uart   <= 1'b1;
                  ret_state <= S_PAY;
                  state     <= S_GAP;
`ifdef OWN_DATA_CHKSUM_EN
                  chk       <= PLAYER_ID;
`endif
               end
            end
            S_PAY: begin
               if (!tx_full) begin
                  tx_data <= pay_byte;
                  wr_uart <= 1'b1;
                  state   <= S_GAP;
`ifdef OWN_DATA_CHKSUM_EN
                  chk     <= chk ^ pay_byte;
`endif
                  if (idx == LAST_IDX) begin
`ifdef OWN_DATA_CHKSUM_EN
                     ret_state <= S_CHK;
`else
                     ret_state <= S_IDLE;
                     frame_cnt <= frame_cnt + 16'd1;
`endif
                  end else begin
                     idx       <= idx + 1'b1;
                     ret_state <= S_PAY;
                  end
               end
            end
`ifdef OWN_DATA_CHKSUM_EN
            S_CHK: begin
               if (!tx_full) begin
                  tx_data   <= chk;
                  wr_uart   <= 1'b1;
                  ret_state <= S_IDLE;
                  state     <= S_GAP;
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end
`endif
            S_GAP: begin
               state <= ret_state;
               if (ret_state == S_IDLE) busy <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_own_data_framer.sv
// tb_own_data_framer: randomized self-checking bench for own_data_framer.
// Two instances share all inputs: 'dut' with a keep-alive period too long to
// matter, and 'ka' with REFRESH=20 for the keep-alive scenario. Expected byte
// streams and write edges are computed from the frame rules (byte list,
// one write per two edges, one extra edge per stalled cycle).
module tb_own_data_framer;

   localparam int         NB        = 2;
   localparam logic [7:0] SYNC_B    = 8'hA5;
   localparam logic [7:0] PID       = 8'h01;
   localparam int         KA_PERIOD = 20;
`ifdef OWN_DATA_CHKSUM_EN
   localparam bit         CHK_ON    = 1'b1;
`else
   localparam bit         CHK_ON    = 1'b0;
`endif
   localparam int         HMAX      = 4096;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_full = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic [7:0]  tx_data, ka_tx_data;
   logic        wr_uart, ka_wr_uart;
   logic        busy, ka_busy;
   logic [15:0] frame_cnt, ka_frame_cnt;

   always #5 clk = ~clk;

   own_data_framer #(.NBYTES(NB), .SYNC(SYNC_B), .PLAYER_ID(PID), .REFRESH(1_000_000)) dut (
      .clk(clk), .rst(rst), .tx_full(tx_full), .in_data(in_data),
      .tx_data(tx_data), .wr_uart(wr_uart), .busy(busy), .frame_cnt(frame_cnt)
   );

   own_data_framer #(.NBYTES(NB), .SYNC(SYNC_B), .PLAYER_ID(PID), .REFRESH(KA_PERIOD)) ka (
      .clk(clk), .rst(rst), .tx_full(tx_full), .in_data(in_data),
      .tx_data(ka_tx_data), .wr_uart(ka_wr_uart), .busy(ka_busy), .frame_cnt(ka_frame_cnt)
   );

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [7:0]  got_q[$];
   int          got_t[$];
   logic [7:0]  ka_q[$];
   int          ka_t[$];
   logic        busy_h[0:HMAX-1];
   logic [15:0] fc_h[0:HMAX-1];
   int          b2b_cnt = 0;
   int          ka_b2b_cnt = 0;
   int          hold_err = 0;
   logic        prev_wr = 1'b0;
   logic        ka_prev_wr = 1'b0;
   logic [7:0]  last_td = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_uart) begin got_q.push_back(tx_data); got_t.push_back(cyc); end
      if (ka_wr_uart) begin ka_q.push_back(ka_tx_data); ka_t.push_back(cyc); end
      if (wr_uart && prev_wr) b2b_cnt++;
      if (ka_wr_uart && ka_prev_wr) ka_b2b_cnt++;
      prev_wr    = wr_uart;
      ka_prev_wr = ka_wr_uart;
      if (rst) last_td = 8'h00;
      else begin
         if (!wr_uart && tx_data !== last_td) hold_err++;
         if (wr_uart) last_td = tx_data;
      end
      if (cyc < HMAX) begin busy_h[cyc] = busy; fc_h[cyc] = frame_cnt; end
   end

   // ---------------- scoreboard / model ----------------
   logic [7:0]  exp_q[$];
   int          exp_t[$];
   bit          full_pat[0:511];
   int          n_tests = 0;
   int          n_fail = 0;
   int          e0 = 0;
   int          exp_fc = 0;
   logic [15:0] cur_v = 16'h0000;

   task automatic clear_all();
      exp_q.delete(); exp_t.delete();
      got_q.delete(); got_t.delete();
      ka_q.delete();  ka_t.delete();
      foreach (full_pat[i]) full_pat[i] = 1'b0;
   endtask

   // Frame = SYNC, ID, payload LSB first, optional ID^payload XOR. Each byte is
   // written at its earliest edge with tx_full low; the next byte is earliest
   // two edges later. Edges are relative to e0.
   task automatic model_frame(input logic [15:0] v, input int start_e, output int last_e);
      logic [7:0] b[$];
      logic [7:0] x;
      int         e;
      b.push_back(SYNC_B);
      b.push_back(PID);
      x = PID;
      for (int i = 0; i < NB; i++) begin
         b.push_back(v[8*i +: 8]);
         x = x ^ v[8*i +: 8];
      end
      if (CHK_ON) b.push_back(x);
      e = start_e;
      last_e = start_e;
      foreach (b[k]) begin
         while (full_pat[e] && e < 511) e++;
         exp_q.push_back(b[k]);
         exp_t.push_back(e0 + e);
         last_e = e;
         e += 2;
      end
   endtask

   // ---------------- driver ----------------
   // Caller sets e0 = cyc + 1 right before calling; the first edge is E0.
   task automatic drive(input logic [15:0] v, input int ncyc, input int mid_e,
                        input logic [15:0] mid_v, input int rst_e);
      rst = 1'b0;
      in_data = v;
      @(posedge clk); #2;
      for (int e = 1; e <= ncyc && e < 512; e++) begin
         tx_full = full_pat[e];
         rst = (e == rst_e);
         if (e == mid_e) in_data = mid_v;
         @(posedge clk); #2;
      end
      tx_full = 1'b0;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int last;
      rst = 1'b1; in_data = 16'h0000; tx_full = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %02h expected 00", tx_data); end
      n_tests++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset wr_uart: got %b expected 0", wr_uart); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
      n_tests++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt); end
      clear_all();
      e0 = cyc + 1;
      model_frame(16'h0000, 1, last);
      drive(16'h0000, last + 12, 0, 16'h0000, 0);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_frame count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
            n_fail++; $display("FAIL reset_frame write %0d: got %02h at edge %0d, expected %02h at edge %0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
         end
      end
      n_tests++; if (busy_h[e0] !== 1'b1) begin n_fail++; $display("FAIL reset_busy_rise: got %b expected 1", busy_h[e0]); end
      n_tests++; if (busy_h[e0+last] !== 1'b1) begin n_fail++; $display("FAIL reset_busy_last: got %b expected 1", busy_h[e0+last]); end
      n_tests++; if (busy_h[e0+last+1] !== 1'b0) begin n_fail++; $display("FAIL reset_busy_fall: got %b expected 0", busy_h[e0+last+1]); end
      n_tests++; if (fc_h[e0+last-1] !== 16'd0) begin n_fail++; $display("FAIL reset_fc_before: got %0d expected 0", fc_h[e0+last-1]); end
      n_tests++; if (fc_h[e0+last] !== 16'd1) begin n_fail++; $display("FAIL reset_fc_after: got %0d expected 1", fc_h[e0+last]); end
      exp_fc = 1;
      cur_v = 16'h0000;
   endtask

   task automatic test_keepalive();
      int last;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      clear_all();
      e0 = cyc + 1;
      model_frame(cur_v, 1, last);
      for (int k = 0; k < 3; k++) model_frame(cur_v, last + 2 + KA_PERIOD, last);
      drive(cur_v, last + 6, 0, 16'h0000, 0);
      n_tests++;
      if (ka_q.size() != exp_q.size()) begin n_fail++; $display("FAIL keepalive count: got %0d writes expected %0d", ka_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ka_q.size(); i++) begin
         n_tests++;
         if (ka_q[i] !== exp_q[i] || ka_t[i] != exp_t[i]) begin
            n_fail++; $display("FAIL keepalive write %0d: got %02h at edge %0d, expected %02h at edge %0d", i, ka_q[i], ka_t[i], exp_q[i], exp_t[i]);
         end
      end
      n_tests++; if (ka_frame_cnt !== 16'd4) begin n_fail++; $display("FAIL keepalive frame_cnt: got %0d expected 4", ka_frame_cnt); end
      exp_fc = 1;
      n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL keepalive dut frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_pattern();
      int          last;
      logic [15:0] v;
      for (int n = 0; n < 4; n++) begin
         v = (n == 0) ? 16'h1234 : 16'($urandom);
         if (v == cur_v) v = v ^ 16'h0001;
         clear_all();
         e0 = cyc + 1;
         model_frame(v, 1, last);
         drive(v, last + 4, 0, 16'h0000, 0);
         n_tests++;
         if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pattern %04h count: got %0d writes expected %0d", v, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
               n_fail++; $display("FAIL pattern %04h write %0d: got %02h at edge %0d, expected %02h at edge %0d", v, i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
         end
         exp_fc++;
         n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL pattern frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
         cur_v = v;
      end
   endtask

   task automatic test_midframe_change();
      int          last;
      logic [15:0] v;
      do v = 16'($urandom); while (v == cur_v || v == 16'hBEEF);
      clear_all();
      e0 = cyc + 1;
      model_frame(v, 1, last);
      model_frame(16'hBEEF, last + 3, last);
      drive(v, last + 4, 4, 16'hBEEF, 0);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midframe count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
            n_fail++; $display("FAIL midframe write %0d: got %02h at edge %0d, expected %02h at edge %0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
         end
      end
      exp_fc += 2;
      n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL midframe frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      cur_v = 16'hBEEF;
   endtask

   task automatic test_backpressure();
      int last;
      clear_all();
      for (int e = 5; e <= 14; e++) full_pat[e] = 1'b1;
      e0 = cyc + 1;
      model_frame(16'h1234, 1, last);
      drive(16'h1234, last + 4, 0, 16'h0000, 0);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL backpressure count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
            n_fail++; $display("FAIL backpressure write %0d: got %02h at edge %0d, expected %02h at edge %0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
         end
      end
      exp_fc++;
      n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL backpressure frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      cur_v = 16'h1234;
   endtask

   task automatic test_random_stall();
      int          last;
      logic [15:0] v;
      for (int n = 0; n < 3; n++) begin
         do v = 16'($urandom); while (v == cur_v);
         clear_all();
         for (int e = 1; e <= 60; e++) full_pat[e] = ($urandom_range(0, 2) == 0);
         e0 = cyc + 1;
         model_frame(v, 1, last);
         drive(v, last + 4, 0, 16'h0000, 0);
         n_tests++;
         if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall %04h count: got %0d writes expected %0d", v, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
               n_fail++; $display("FAIL stall %04h write %0d: got %02h at edge %0d, expected %02h at edge %0d", v, i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
         end
         exp_fc++;
         n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL stall frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
         cur_v = v;
      end
   endtask

   task automatic test_reset_midframe();
      int          last;
      logic [15:0] v;
      do v = 16'($urandom); while (v == cur_v);
      clear_all();
      e0 = cyc + 1;
      exp_q.push_back(SYNC_B);
      exp_t.push_back(e0 + 1);
      model_frame(v, 5, last);
      drive(v, last + 4, 0, 16'h0000, 3);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_mid count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
            n_fail++; $display("FAIL rst_mid write %0d: got %02h at edge %0d, expected %02h at edge %0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
         end
      end
      n_tests++; if (fc_h[e0+3] !== 16'd0) begin n_fail++; $display("FAIL rst_mid fc_cleared: got %0d expected 0", fc_h[e0+3]); end
      n_tests++; if (busy_h[e0+3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy_cleared: got %b expected 0", busy_h[e0+3]); end
      exp_fc = 1;
      n_tests++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL rst_mid frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      cur_v = v;
   endtask

   task automatic test_protocol();
      n_tests++; if (b2b_cnt != 0) begin n_fail++; $display("FAIL b2b dut: got %0d back-to-back writes expected 0", b2b_cnt); end
      n_tests++; if (ka_b2b_cnt != 0) begin n_fail++; $display("FAIL b2b ka: got %0d back-to-back writes expected 0", ka_b2b_cnt); end
      n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL tx_data_hold: got %0d changes while idle expected 0", hold_err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_keepalive();
      test_pattern();
      test_midframe_change();
      test_backpressure();
      test_random_stall();
      test_reset_midframe();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/own_data_framer.md
# own_data_framer

Parametrised per-player state transmitter placed between player game logic and the UART TX FIFO. It snapshots a multi-byte local state word and serialises it as a framed packet: sync byte, player ID, payload and an optional XOR checksum. The FIFO is written one byte at a time under `tx_full` back-pressure. A frame is sent on any state change and on a periodic keep-alive timer, replacing unconditional every-cycle writes.

## Interface
Parameters:
- `NBYTES`, default 2: payload bytes per frame (1..8).
- `SYNC`, default 8'hA5: frame start byte.
- `PLAYER_ID`, default 8'h01: ID byte inserted after `SYNC`.
- `REFRESH`, default 1_000_000: keep-alive period in clk cycles; 0 disables keep-alive.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_full`  in  1  UART TX FIFO full flag.
- `in_data`  in  8*NBYTES  local player state, sampled continuously.
- `tx_data`  out  8  byte to FIFO, valid while `wr_uart`=1.
- `wr_uart`  out  1  FIFO write strobe, one-cycle pulse per byte.
- `busy`  out  1  frame in progress (snapshot frozen).
- `frame_cnt`  out  16  completed frames, wraps 16'hFFFF→0.

## Operation
- All outputs are registered. Reset values: `tx_data`=0, `wr_uart`=0, `busy`=0, `frame_cnt`=0.
- Internal reset state:
  - `last_sent`=0.
  - Refresh timer=0.
  - `force` flag=1, so exactly one frame is sent right after reset regardless of `in_data`.
- States: IDLE, SYNC, ID, PAY, CHK, GAP.
  - GAP is entered after every byte write.
  - GAP returns to the next byte state or to IDLE.
- IDLE:
  - Trigger = `force` OR `in_data`≠`last_sent` OR (REFRESH≠0 AND timer==REFRESH-1).
  - On trigger: latch `snap`=`in_data` and `last_sent`=`in_data`; clear `force` and the timer; set `busy`=1; go to SYNC.
  - Otherwise the timer increments, saturating at REFRESH-1.
- Byte states (SYNC, ID, PAY, CHK):
  - If `tx_full`=0 at the edge: load `tx_data`, set `wr_uart`=1, go to GAP.
  - If `tx_full`=1: hold the state; `wr_uart` stays 0.
- GAP:
  - `wr_uart`=0, so `tx_full` can reflect the write just made. Writes are therefore never back-to-back.
  - Next state is ID, PAY, CHK or IDLE, in frame order.
- Byte order:
  - `SYNC`, then `PLAYER_ID`.
  - Then `snap[7:0]`, `snap[15:8]`, … up to byte NBYTES-1, using a payload index counter of width clog2(NBYTES)+1.
  - Then the checksum = `PLAYER_ID` XOR all payload bytes (`SYNC` excluded).
- On the final byte's write edge, `frame_cnt` increments. On the following GAP→IDLE edge, `busy`→0.
- `in_data` changes while `busy`=1 do not affect the current frame. After return to IDLE they are detected against `last_sent` and produce a new frame.
- The timer does not run while `busy`=1.
- `rst` mid-frame aborts the frame immediately: no further writes, all state returns to reset values, `force`=1.

## Timing
- Trigger seen at edge E0 → `busy`=1 after E0. With `tx_full` held low:
  - Writes at E1, E3, E5, … (one byte every 2 cycles).
  - Frame length L = NBYTES+3 bytes (NBYTES+2 without checksum).
  - Last write at E(2L-1); `busy`=0 after E(2L).
  - Earliest next trigger at E(2L+1).
- Each cycle of `tx_full`=1 in a byte state adds exactly one cycle of delay.
- `wr_uart` is never high for two consecutive cycles.
- `tx_data` holds its last value while `wr_uart`=0.

## Configuration
- `OWN_DATA_CHKSUM_EN` defined: CHK state present; frame = SYNC, ID, NBYTES payload, checksum.
- Not defined: CHK state removed; after the last payload byte's GAP, go to IDLE. Frame = NBYTES+2 bytes; `frame_cnt` increments on the last payload write.

## Test plan
- Reset release with `in_data`=0, `tx_full`=0, NBYTES=2, checksum on → 5 writes A5, 01, 00, 00, 01 at E1/E3/E5/E7/E9; then `frame_cnt`=1, `busy`=0, no further writes.
- `in_data`=16'h1234 in IDLE → frame A5, 01, 34, 12, 27.
- `tx_full`=1 for 10 cycles while in the PAY state → no `wr_uart`. Byte 34 is written on the first edge with `tx_full`=0; the frame then completes unchanged.
- `in_data` changes to 16'hBEEF mid-frame → current frame carries the old snapshot. A second frame A5, 01, EF, BE, 50 follows; `frame_cnt`+=2 in total.
- REFRESH=20, `in_data` constant after the first frame → a repeat frame triggers every 20 idle cycles, with identical bytes each time.
- `rst` pulse during the ID byte → `wr_uart` stays 0 until the post-reset forced frame starting with A5; `frame_cnt` restarts at 0→1.
